// File: rtl/fetcher.sv
// Instruction-fetch stage: direct-mapped one-word-per-line instruction cache
// with miss refill from memory and one-cycle result pulses to decoder and PC controller.
module fetcher #(
    parameter int unsigned ICACHE_ENTRIES = 16
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_rdy,
    input  logic        in_flush_enable,
    input  logic        in_pc_enable,
    input  logic [31:0] in_pc_addr,
    input  logic        in_pc_predict,
    output logic        out_pc_last_enable,
    output logic [31:0] out_pc_last_inst,
    output logic        out_mem_enable,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_done,
    input  logic [31:0] in_mem_inst,
    output logic        out_inst_enable,
    output logic [31:0] out_inst,
    output logic [31:0] out_inst_pc,
    output logic        out_inst_predict
);

    localparam int unsigned IDX   = $clog2(ICACHE_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX - 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t state;

    logic [31:0]               line_data [ICACHE_ENTRIES];
    logic [TAG_W-1:0]          line_tag  [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0] line_valid;

    logic [31:0] req_pc;
    logic        req_predict;

    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_we;

    always_comb begin
        look_idx = in_pc_addr[IDX+1:2];
        look_tag = in_pc_addr[31:IDX+2];
        look_hit = line_valid[look_idx] && (line_tag[look_idx] == look_tag);
        fill_idx = req_pc[IDX+1:2];
        fill_tag = req_pc[31:IDX+2];
        // A flushed or stalled miss must never write the line.
        fill_we  = in_rdy && !in_flush_enable && (state == S_MISS) && in_mem_done;
    end

    always_ff @(posedge in_clk) begin
        if (fill_we) begin
            line_data[fill_idx] <= in_mem_inst;
            line_tag[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state              <= S_IDLE;
            line_valid         <= '0;
            req_pc             <= '0;
            req_predict        <= 1'b0;
            out_pc_last_enable <= 1'b0;
            out_pc_last_inst   <= '0;
            out_mem_enable     <= 1'b0;
            out_mem_addr       <= '0;
            out_inst_enable    <= 1'b0;
            out_inst           <= '0;
            out_inst_pc        <= '0;
            out_inst_predict   <= 1'b0;
        end else begin
            // Pulses default low every edge, including stalled ones.
            out_inst_enable    <= 1'b0;
            out_pc_last_enable <= 1'b0;
            if (in_rdy) begin
                if (in_flush_enable) begin
                    state          <= S_IDLE;
                    out_mem_enable <= 1'b0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (in_pc_enable) begin
                                req_pc      <= in_pc_addr;
                                req_predict <= in_pc_predict;
                                if (look_hit) begin
                                    out_inst_enable    <= 1'b1;
                                    out_pc_last_enable <= 1'b1;
                                    out_inst           <= line_data[look_idx];
                                    out_pc_last_inst   <= line_data[look_idx];
                                    out_inst_pc        <= in_pc_addr;
                                    out_inst_predict   <= in_pc_predict;
                                end else begin
                                    out_mem_enable <= 1'b1;
                                    out_mem_addr   <= in_pc_addr;
                                    state          <= S_MISS;
                                end
                            end
                        end
                        S_MISS: begin
                            if (in_mem_done) begin
                                line_valid[fill_idx] <= 1'b1;
                                out_mem_enable       <= 1'b0;
                                out_inst_enable      <= 1'b1;
                                out_pc_last_enable   <= 1'b1;
                                out_inst             <= in_mem_inst;
                                out_pc_last_inst     <= in_mem_inst;
                                out_inst_pc          <= req_pc;
                                out_inst_predict     <= req_predict;
                                state                <= S_IDLE;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch stage between the PC controller and the decoder. Accepts one fetch request per instruction from the PC controller, serves it from a direct-mapped instruction cache or fills the cache from the memory controller on a miss, then hands the instruction to the decoder. It also returns the instruction to the PC controller for next-PC prediction. A pipeline flush discards any in-flight fetch.

## Interface
Parameters:
- ICACHE_ENTRIES, 16, number of direct-mapped lines, one 32-bit word each; power of two, at least 2.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge
- in_rst  input  1  reset, asynchronous, active-high
- in_rdy  input  1  global ready; state is sampled and updated only on edges where in_rdy=1
- in_flush_enable  input  1  mispredict flush from commit
- in_pc_enable  input  1  fetch request from the PC controller
- in_pc_addr  input  32  fetch address, word-aligned
- in_pc_predict  input  1  prediction bit travelling with the instruction
- out_pc_last_enable  output  1  one-cycle pulse: fetched instruction is available to the PC controller
- out_pc_last_inst  output  32  fetched instruction
- out_mem_enable  output  1  memory read request, held until done
- out_mem_addr  output  32  memory read address
- in_mem_done  input  1  memory read complete, one-cycle pulse
- in_mem_inst  input  32  read data, valid when in_mem_done=1
- out_inst_enable  output  1  one-cycle pulse to the decoder
- out_inst  output  32  instruction to the decoder
- out_inst_pc  output  32  address of the instruction
- out_inst_predict  output  1  prediction bit of the instruction

## Operation
**Cache organisation**
- Line index is addr[IDX+1:2], where IDX = log2(ICACHE_ENTRIES).
- Tag is addr[31:IDX+2]. Each line has a valid bit.
- Hit means the indexed line is valid and its tag matches.

**States: IDLE, MISS.**

**IDLE**
- When in_pc_enable=1, latch in_pc_addr and in_pc_predict into the request registers.
- On a hit, pulse out_inst_enable and out_pc_last_enable with the cached word. Stay in IDLE.
- On a miss, set out_mem_enable=1 and out_mem_addr=in_pc_addr, then go to MISS.

**MISS**
- Hold out_mem_enable and out_mem_addr.
- Ignore in_pc_enable. The PC controller never issues a request before out_pc_last_enable, except after a flush.
- When in_mem_done=1:
  - Write in_mem_inst into the indexed line, update its tag, and set its valid bit.
  - Clear out_mem_enable.
  - Pulse both output handshakes with in_mem_inst and the latched pc/predict.
  - Go to IDLE.

**Flush** (in_flush_enable=1) has top priority.
- Go to IDLE, clear out_mem_enable, and clear both pulse outputs.
- A request arriving on the same edge is dropped.
- The cache is not invalidated, and a line is never written by a flushed miss.
- An in_mem_done arriving while in IDLE is ignored. The memory controller is flushed by the same signal.

**in_rdy=0**
- No state, cache, or request-register change.
- out_inst_enable and out_pc_last_enable are driven 0 on that edge, so a pulse never stretches.
- out_mem_enable and out_mem_addr hold.

**Reset values**
- State IDLE; all valid bits 0.
- out_inst_enable=0, out_pc_last_enable=0, out_mem_enable=0.
- out_mem_addr, out_inst, out_pc_last_inst, and out_inst_pc are all 0; out_inst_predict=0.
- Reset asserted mid-miss abandons the miss immediately.

**Output values**
- out_inst and out_pc_last_inst always carry the same word.
- out_inst_pc and out_inst_predict carry the values latched with the request.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- **Hit:** request sampled at edge E. Pulses are high for exactly the cycle after E.
- **Miss:** request sampled at edge E. out_mem_enable rises after E. in_mem_done is sampled at edge D (D ≥ E+1). out_mem_enable falls and the pulses are high for exactly the cycle after D.
- Throughput: one hit per cycle is possible, provided requests arrive back-to-back.
- A write filled at D is visible to a hit lookup at D+1.

## Test plan
1. **Reset:** assert in_rst asynchronously mid-cycle. All outputs 0 immediately; a later lookup of 0x0 misses.
2. **Cold miss:** in_pc_enable with addr 0x00000010, predict=1. out_mem_enable rises with addr 0x10. Memory returns done 3 cycles later with 0x00A00093. One pulse follows on both ports with inst 0x00A00093, pc 0x10, predict 1.
3. **Hit:** re-request 0x10 (ICACHE_ENTRIES=16). Pulse appears the next cycle with 0x00A00093 and no memory request. A request to 0x50 (same index, different tag) misses and evicts; 0x10 then misses again.
4. **Flush during miss:** request 0x20, then in_flush_enable before done. out_mem_enable drops, no pulse is produced, and a late in_mem_done is ignored. A later request to 0x20 misses again.
5. **Flush with simultaneous request:** the request is dropped and nothing is emitted.
6. **in_rdy=0:** drop in_rdy for 2 cycles during a miss. out_mem_enable holds and done is not consumed until in_rdy=1. Dropping in_rdy on a hit pulse cuts the pulse to 0.
